// File: rtl/yarvi_mem_arb.sv
// Arbiter for the shared single-ported memory: ME stage vs host/debug loader port.
// Optional perf counters are built when YARVI_ARB_PERF_EN is defined.
module yarvi_mem_arb #(
    parameter int AW            = 32,
    parameter int DW            = 64,
    parameter int HOST_WAIT_MAX = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            me_req,
    input  logic            me_we,
    input  logic [AW-1:0]   me_addr,
    input  logic [DW-1:0]   me_wdata,
    input  logic [DW/8-1:0] me_wmask,
    output logic            me_ready,
    output logic            me_rvalid,
    output logic [DW-1:0]   me_rdata,
    input  logic            host_req,
    input  logic            host_we,
    input  logic [AW-1:0]   host_addr,
    input  logic [DW-1:0]   host_wdata,
    input  logic [DW/8-1:0] host_wmask,
    output logic            host_ready,
    output logic            host_rvalid,
    output logic [DW-1:0]   host_rdata,
    input  logic            host_lock,
    output logic            ex_stall,
    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wmask,
    input  logic [DW-1:0]   mem_rdata,
    output logic [31:0]     perf_me_stall,
    output logic [31:0]     perf_host_grant
);

    typedef enum logic {ARB, HOST_LOCK} state_e;

    localparam logic [3:0] WAIT_MAX = 4'(HOST_WAIT_MAX);

    state_e     state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       rd_pend_q, rd_pend_d;
    logic       rd_owner_q, rd_owner_d;  // 1 = host owns the read in flight
    logic       me_gnt, host_gnt;

    // Grant is forced low while reset is asserted so nothing reaches the memory.
    always_comb begin
        me_gnt   = 1'b0;
        host_gnt = 1'b0;
        if (state_q == HOST_LOCK) begin
            host_gnt = host_req;
        end else if (me_req && host_req) begin
            if (wait_cnt_q == WAIT_MAX) host_gnt = 1'b1;
            else                        me_gnt   = 1'b1;
        end else begin
            me_gnt   = me_req;
            host_gnt = host_req;
        end
        if (!reset) begin
            me_gnt   = 1'b0;
            host_gnt = 1'b0;
        end
    end

    assign me_ready   = me_gnt;
    assign host_ready = host_gnt;
    assign ex_stall   = reset & me_req & ~me_gnt;

    always_comb begin
        mem_en    = me_gnt | host_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wmask = '0;
        if (host_gnt) begin
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
            mem_wmask = host_wmask;
        end else if (me_gnt) begin
            mem_we    = me_we;
            mem_addr  = me_addr;
            mem_wdata = me_wdata;
            mem_wmask = me_wmask;
        end
    end

    assign me_rvalid   = reset & rd_pend_q & ~rd_owner_q;
    assign host_rvalid = reset & rd_pend_q & rd_owner_q;
    assign me_rdata    = reset ? mem_rdata : '0;
    assign host_rdata  = reset ? mem_rdata : '0;

    always_comb begin
        state_d = state_q;
        if (state_q == ARB) begin
            if (host_gnt && host_lock) state_d = HOST_LOCK;
        end else if (!host_lock) begin
            state_d = ARB;
        end

        wait_cnt_d = wait_cnt_q;
        if (!host_req || host_gnt)        wait_cnt_d = '0;
        else if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + 4'd1;

        rd_pend_d  = (me_gnt | host_gnt) & ~mem_we;
        rd_owner_d = host_gnt;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ARB;
            wait_cnt_q <= '0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

`ifdef YARVI_ARB_PERF_EN
    logic [31:0] perf_me_stall_q, perf_host_grant_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_me_stall_q   <= '0;
            perf_host_grant_q <= '0;
        end else begin
            perf_me_stall_q   <= perf_me_stall_q + {31'd0, ex_stall};
            perf_host_grant_q <= perf_host_grant_q + {31'd0, host_gnt};
        end
    end

    assign perf_me_stall   = reset ? perf_me_stall_q : '0;
    assign perf_host_grant = reset ? perf_host_grant_q : '0;
`else
    assign perf_me_stall   = '0;
    assign perf_host_grant = '0;
`endif

endmodule

// File: tb/tb_yarvi_mem_arb.sv
// Bench for yarvi_mem_arb: directed scenarios plus randomized traffic against a reference model.
module tb_yarvi_mem_arb;
    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int HWM = 4;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            me_req = 0, me_we = 0, host_req = 0, host_we = 0, host_lock = 0;
    logic [AW-1:0]   me_addr = 0, host_addr = 0;
    logic [DW-1:0]   me_wdata = 0, host_wdata = 0, mem_rdata = 0;
    logic [DW/8-1:0] me_wmask = 0, host_wmask = 0;
    logic            me_ready, me_rvalid, host_ready, host_rvalid, ex_stall;
    logic [DW-1:0]   me_rdata, host_rdata, mem_wdata;
    logic            mem_en, mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW/8-1:0] mem_wmask;
    logic [31:0]     perf_me_stall, perf_host_grant;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit m_locked;
    int m_wait;
    int m_pend;      // -1 none, 0 ME, 1 host
    int m_stalls, m_hgrants;
    bit e_me_acc, e_host_acc;

    yarvi_mem_arb #(.AW(AW), .DW(DW), .HOST_WAIT_MAX(HWM)) dut (
        .clock(clock), .reset(reset),
        .me_req(me_req), .me_we(me_we), .me_addr(me_addr), .me_wdata(me_wdata),
        .me_wmask(me_wmask), .me_ready(me_ready), .me_rvalid(me_rvalid), .me_rdata(me_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_wmask(host_wmask), .host_ready(host_ready), .host_rvalid(host_rvalid),
        .host_rdata(host_rdata), .host_lock(host_lock), .ex_stall(ex_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
        .perf_me_stall(perf_me_stall), .perf_host_grant(perf_host_grant)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        me_req = 0; me_we = 0; me_addr = 0; me_wdata = 0; me_wmask = 0;
        host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0; host_wmask = 0;
        host_lock = 0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        m_locked = 0; m_wait = 0; m_pend = -1; m_stalls = 0; m_hgrants = 0;
        e_me_acc = 0; e_host_acc = 0;
    endtask

    // Who wins this cycle, from the arbitration rules
    task automatic model_eval();
        e_me_acc = 0; e_host_acc = 0;
        if (m_locked)                 e_host_acc = host_req;
        else if (me_req && host_req)  begin if (m_wait == HWM) e_host_acc = 1; else e_me_acc = 1; end
        else begin e_me_acc = me_req; e_host_acc = host_req; end
    endtask

    task automatic model_step();
        bit acc_we;
        acc_we = e_host_acc ? host_we : me_we;
        if (me_req && !e_me_acc) m_stalls++;
        if (e_host_acc) m_hgrants++;
        m_pend = ((e_me_acc || e_host_acc) && !acc_we) ? (e_host_acc ? 1 : 0) : -1;
        if (!host_req || e_host_acc) m_wait = 0;
        else m_wait = (m_wait + 1 > HWM) ? HWM : m_wait + 1;
        m_locked = m_locked ? host_lock : (e_host_acc && host_lock);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        me_req = 1; host_req = 1; host_lock = 1;
        #2;
        n_tests++;
        if ({me_ready, host_ready, ex_stall, mem_en, me_rvalid, host_rvalid} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got %b want 000000",
                     {me_ready, host_ready, ex_stall, mem_en, me_rvalid, host_rvalid});
        end
        n_tests++;
        if ({perf_me_stall, perf_host_grant} !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_perf got %0d/%0d want 0/0", perf_me_stall, perf_host_grant);
        end
        apply_reset();
        #2;
        n_tests++;
        if ({me_ready, host_ready, mem_en, me_rvalid, host_rvalid} !== 5'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle got %b want 00000",
                     {me_ready, host_ready, mem_en, me_rvalid, host_rvalid});
        end
        tick();
    endtask

    task automatic test_single_read();
        logic [DW-1:0] rd;
        me_req = 1; me_we = 0; me_addr = 32'h100;
        #2;
        n_tests++;
        if ({me_ready, mem_en, mem_we, mem_addr} !== {3'b110, 32'h100}) begin
            n_fail++;
            $display("FAIL single_read_issue got rdy=%b en=%b we=%b addr=%h want 1 1 0 00000100",
                     me_ready, mem_en, mem_we, mem_addr);
        end
        tick();
        me_req = 0;
        rd = {$urandom, $urandom};
        mem_rdata = rd;
        #2;
        n_tests++;
        if ({me_rvalid, host_rvalid} !== 2'b10 || me_rdata !== rd) begin
            n_fail++;
            $display("FAIL single_read_return got rv=%b%b data=%h want 10 data=%h",
                     me_rvalid, host_rvalid, me_rdata, rd);
        end
        tick();
        #2;
        n_tests++;
        if (me_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_read_one_pulse got %b want 0", me_rvalid);
        end
        tick();
    endtask

    task automatic test_tie();
        me_req = 1; me_we = 1; me_addr = 32'h200;
        host_req = 1; host_we = 1; host_addr = 32'h300;
        for (int k = 0; k < 15; k++) begin
            #2;
            n_tests++;
            if ({me_ready, host_ready, ex_stall} !== ((k % 5 == 4) ? 3'b011 : 3'b100)) begin
                n_fail++;
                $display("FAIL tie_cycle%0d got me/host/stall=%b want %b", k,
                         {me_ready, host_ready, ex_stall}, (k % 5 == 4) ? 3'b011 : 3'b100);
            end
            tick();
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_lock();
        int stalls = 0;
        host_req = 1; host_we = 1; host_addr = 32'h80; host_wdata = 64'hdead_beef; host_wmask = 8'hff;
        host_lock = 1;
        #2;
        n_tests++;
        if ({host_ready, mem_en, mem_we, mem_addr} !== {3'b111, 32'h80}) begin
            n_fail++;
            $display("FAIL lock_host_write got rdy=%b en=%b we=%b addr=%h want 1 1 1 00000080",
                     host_ready, mem_en, mem_we, mem_addr);
        end
        tick();
        host_req = 0;
        me_req = 1; me_we = 0; me_addr = 32'h40;
        for (int k = 1; k <= 5; k++) begin
            host_lock = (k <= 3);
            #2;
            if (ex_stall) stalls++;
            n_tests++;
            if (me_ready !== (k == 5) || (k == 1 && {me_rvalid, host_rvalid} !== 2'b00)) begin
                n_fail++;
                $display("FAIL lock_cycle%0d got me_ready=%b rv=%b%b want %b 00", k,
                         me_ready, me_rvalid, host_rvalid, k == 5);
            end
            tick();
        end
        n_tests++;
        if (stalls != 4) begin
            n_fail++;
            $display("FAIL lock_stall_count got %0d want 4", stalls);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_host_alone();
        host_req = 1;
        for (int k = 0; k < 10; k++) begin
            host_we = 1'($urandom); host_addr = $urandom;
            #2;
            n_tests++;
            if ({host_ready, me_ready, mem_addr} !== {2'b10, host_addr}) begin
                n_fail++;
                $display("FAIL host_alone_%0d got h/m=%b%b addr=%h want 10 addr=%h", k,
                         host_ready, me_ready, mem_addr, host_addr);
            end
            tick();
        end
        me_req = 1; me_we = 1;
        for (int k = 0; k < 4; k++) begin
            #2;
            n_tests++;
            if ({me_ready, host_ready} !== 2'b10) begin
                n_fail++;
                $display("FAIL host_alone_then_me_%0d got me/host=%b want 10", k, {me_ready, host_ready});
            end
            tick();
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_read();
        me_req = 1; me_we = 0; me_addr = 32'h500;
        #2;
        n_tests++;
        if (me_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_read_issue got %b want 1", me_ready);
        end
        tick();
        apply_reset();
        for (int k = 0; k < 2; k++) begin
            #2;
            n_tests++;
            if ({me_rvalid, host_rvalid} !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_read_discard_%0d got %b%b want 00", k, me_rvalid, host_rvalid);
            end
            tick();
        end
        me_req = 1; me_we = 1; host_req = 1; host_we = 1;
        for (int k = 0; k < 5; k++) begin
            #2;
            n_tests++;
            if ({me_ready, host_ready} !== ((k == 4) ? 2'b01 : 2'b10)) begin
                n_fail++;
                $display("FAIL reset_read_arb_%0d got me/host=%b want %b", k,
                         {me_ready, host_ready}, (k == 4) ? 2'b01 : 2'b10);
            end
            tick();
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_perf();
        logic [63:0] want;
        apply_reset();
        me_req = 1; me_we = 1; host_req = 1; host_we = 1;
        repeat (10) tick();
        clear_inputs();
        #2;
`ifdef YARVI_ARB_PERF_EN
        want = {32'd2, 32'd2};
`else
        want = 64'd0;
`endif
        n_tests++;
        if ({perf_me_stall, perf_host_grant} !== want) begin
            n_fail++;
            $display("FAIL perf_tie got stall=%0d grant=%0d want %0d/%0d",
                     perf_me_stall, perf_host_grant, want[63:32], want[31:0]);
        end
        tick();
    endtask

    task automatic test_random();
        logic [105:0] exp_bus;
        logic [63:0]  want_perf;
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            if (!me_req || e_me_acc) begin
                me_req = ($urandom_range(0, 9) < 7);
                me_we = 1'($urandom); me_addr = $urandom;
                me_wdata = {$urandom, $urandom}; me_wmask = 8'($urandom);
            end
            if (!host_req || e_host_acc) begin
                host_req = ($urandom_range(0, 9) < 5);
                host_we = 1'($urandom); host_addr = $urandom;
                host_wdata = {$urandom, $urandom}; host_wmask = 8'($urandom);
            end
            host_lock = ($urandom_range(0, 3) == 0);
            mem_rdata = {$urandom, $urandom};
            #2;
            model_eval();
            if (e_host_acc)    exp_bus = {1'b1, host_we, host_addr, host_wdata, host_wmask};
            else if (e_me_acc) exp_bus = {1'b1, me_we, me_addr, me_wdata, me_wmask};
            else               exp_bus = '0;
            n_tests++;
            if ({me_ready, host_ready, ex_stall} !== {e_me_acc, e_host_acc, me_req & ~e_me_acc}) begin
                n_fail++;
                $display("FAIL rand_ready_%0d got %b want %b", i, {me_ready, host_ready, ex_stall},
                         {e_me_acc, e_host_acc, me_req & ~e_me_acc});
            end
            n_tests++;
            if ({mem_en, mem_we, mem_addr, mem_wdata, mem_wmask} !== exp_bus) begin
                n_fail++;
                $display("FAIL rand_membus_%0d got %h want %h", i,
                         {mem_en, mem_we, mem_addr, mem_wdata, mem_wmask}, exp_bus);
            end
            n_tests++;
            if ({me_rvalid, host_rvalid} !== {m_pend == 0, m_pend == 1}
                || me_rdata !== mem_rdata || host_rdata !== mem_rdata) begin
                n_fail++;
                $display("FAIL rand_rvalid_%0d got rv=%b%b data=%h/%h want %b%b data=%h", i,
                         me_rvalid, host_rvalid, me_rdata, host_rdata, m_pend == 0, m_pend == 1, mem_rdata);
            end
            @(posedge clock);
            model_step();
            #1;
        end
        clear_inputs();
        #2;
`ifdef YARVI_ARB_PERF_EN
        want_perf = {32'(m_stalls), 32'(m_hgrants)};
`else
        want_perf = 64'd0;
`endif
        n_tests++;
        if ({perf_me_stall, perf_host_grant} !== want_perf) begin
            n_fail++;
            $display("FAIL rand_perf got %0d/%0d want %0d/%0d", perf_me_stall, perf_host_grant,
                     want_perf[63:32], want_perf[31:0]);
        end
        tick();
    endtask

    initial begin
        #1;
        test_reset();
        test_single_read();
        test_tie();
        test_lock();
        test_host_alone();
        test_reset_read();
        test_perf();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/yarvi_mem_arb.md
Name: yarvi_mem_arb

Overview:
- Arbitrates the single-ported synchronous data/code memory between two requesters: the pipeline ME stage (loads/stores) and a host/debug loader port (program load, memory peek/poke).
- Sits between yarvi_me and the memory array. It drives the pipeline stall when the ME stage is not granted.
- ME has fixed priority, subject to a host starvation guard and a host lock mode for atomic loader bursts.

Parameters:
- AW, 32: address width.
- DW, 64: data width (XLEN).
- HOST_WAIT_MAX, 4: consecutive losing cycles after which the host wins a tie. Legal range is 1..15.

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- me_req  in  1  ME stage access request.
- me_we  in  1  1 = store, 0 = load.
- me_addr  in  AW  byte address.
- me_wdata  in  DW  store data.
- me_wmask  in  DW/8  byte enables.
- me_ready  out  1  ME request accepted this cycle.
- me_rvalid  out  1  ME load data valid.
- me_rdata  out  DW  load data.
- host_req, host_we, host_addr, host_wdata, host_wmask, host_ready, host_rvalid, host_rdata: same as the ME group, for the host port.
- host_lock  in  1  hold the memory for the host after its next accepted access.
- ex_stall  out  1  equals me_req & ~me_ready.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_wmask  out  DW/8  memory byte enables.
- mem_rdata  in  DW  memory read data, valid one cycle after a read strobe.

Behaviour:
- Handshake:
  - A request is accepted in any cycle where req & ready; ready is combinational from current requests and registered state.
  - req and its payload must stay stable until accepted.
  - At most one ready is high per cycle.
- Memory drive:
  - mem_en = accepted.
  - mem_we, mem_addr, mem_wdata and mem_wmask come from the winner, muxed combinationally.
  - All memory outputs are 0 when nothing is accepted.
- Read return:
  - Registered rd_owner and rd_pend.
  - The owner's rvalid pulses exactly one cycle after an accepted read.
  - me_rdata = host_rdata = mem_rdata, unregistered; the rvalid signals discriminate the owner.
  - Writes produce no rvalid.
  - Back-to-back reads give back-to-back rvalid pulses.
- FSM states: ARB, HOST_LOCK.
  - ARB, grant rule:
    - me_req alone → ME.
    - host_req alone → host.
    - Both → ME, unless wait_cnt == HOST_WAIT_MAX, in which case host.
  - ARB → HOST_LOCK: on host accept with host_lock=1.
  - HOST_LOCK: me_ready=0. host_ready = host_req.
  - HOST_LOCK → ARB: on the clock edge where host_lock=0. ME becomes grantable the following cycle.
- wait_cnt (4 bits):
  - Increments, saturating at HOST_WAIT_MAX, each cycle host_req=1 and host is not accepted.
  - Clears on host accept, or when host_req=0.
- Reset (asserted, async):
  - State → ARB; wait_cnt=0; rd_pend=0.
  - me_rvalid = host_rvalid = 0.
  - Outputs are combinationally 0 while reset is low.
  - A pending read return in flight at reset is discarded, not delivered.

Optional Feature:
- Macro: YARVI_ARB_PERF_EN.
- Defined:
  - Adds 32-bit output perf_me_stall, counting cycles with ex_stall=1.
  - Adds 32-bit output perf_host_grant, counting host accepts.
  - Both counters wrap modulo 2^32 and clear on reset.
- Undefined: both ports still exist and are tied to 0; no counter flops are inferred.

Test Plan:
- Single ME read at 0x100, host idle → me_ready=1 in cycle 0, mem_en=1, mem_addr=0x100; me_rvalid=1 in cycle 1 with me_rdata=mem_rdata; host_rvalid=0.
- ME and host both request continuously, HOST_WAIT_MAX=4 → ME wins 4 cycles (ex_stall=0); host wins cycle 5 (ex_stall=1 in that cycle only); pattern repeats every 5 cycles.
- Host write with host_lock=1, then ME request with lock held 3 more cycles → ME stalled 4 cycles total; after lock drops, me_ready=1 on the next cycle.
- Reset asserted the cycle after an accepted ME read → no me_rvalid is ever produced; after release the FSM is in ARB with wait_cnt=0.
- Host requests alone for 10 cycles → host_ready=1 every cycle, wait_cnt stays 0, and a subsequent ME request is granted immediately.
- With YARVI_ARB_PERF_EN defined, run the tie scenario for 10 cycles → perf_me_stall=2, perf_host_grant=2. Undefined → both outputs read 0.
